// File: rtl/conf_int_mac_pipe_acc.sv
// conf_int_mac_pipe_acc: two-stage pipelined unsigned integer MAC with an accumulate mode.
//   mode 0 : d = a*b + c (single shot)
//   mode 1 : d = c + sum(a_i*b_i), opened by 'first', closed and emitted by 'last'
// Only the low OP_BITWIDTH bits of a/b reach the multiplier. The accumulator is
// ACC_BITWIDTH wide and wraps; d is its low DATA_PATH_BITWIDTH bits.
// Optional macro CONF_INT_MAC_SAT_EN: the accumulator and d saturate instead of wrapping,
// and a 'sat' output flags a clipped d alongside out_valid.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid            a/b/c/mode/first/last are valid this cycle
//   mode, first, last   op select and accumulation framing
//   a, b, c             unsigned operands / addend / seed
//   d, out_valid        result (held) and its one-cycle valid pulse
//   busy                an accumulation is open
//   sat                 (macro only) d was clipped
module conf_int_mac_pipe_acc #(
    parameter int unsigned OP_BITWIDTH        = 16,
    parameter int unsigned DATA_PATH_BITWIDTH = 16,
    parameter int unsigned ACC_BITWIDTH       = 40
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          mode,
    input  logic                          first,
    input  logic                          last,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic [DATA_PATH_BITWIDTH-1:0] c,
    output logic [DATA_PATH_BITWIDTH-1:0] d,
    output logic                          out_valid,
    output logic                          busy
`ifdef CONF_INT_MAC_SAT_EN
    ,
    output logic                          sat
`endif
);

    localparam int unsigned ProdW = 2 * OP_BITWIDTH;

    // Stage 1 registers
    logic                          v1_q, v1_d;
    logic [ProdW-1:0]              prod_q, prod_d;
    logic [DATA_PATH_BITWIDTH-1:0] c_q, c_d;
    logic                          mode_q, mode_d;
    logic                          first_q, first_d;
    logic                          last_q, last_d;

    // Stage 2 registers
    logic [ACC_BITWIDTH-1:0]       acc_q, acc_d;
    logic [DATA_PATH_BITWIDTH-1:0] d_q, d_d;
    logic                          out_valid_q, out_valid_d;
    logic                          busy_q, busy_d;
    logic                          sat_q, sat_d;

    logic [OP_BITWIDTH-1:0]        at, bt;
    logic [ACC_BITWIDTH-1:0]       base, acc_new;
    logic [DATA_PATH_BITWIDTH-1:0] d_val;
    logic                          clip;

    // Upper operand bits are deliberately ignored when OP_BITWIDTH < DATA_PATH_BITWIDTH.
    logic unused_ab;
    assign unused_ab = ^{a, b};

    assign at = a[OP_BITWIDTH-1:0];
    assign bt = b[OP_BITWIDTH-1:0];

    // Stage 1: capture product and control; data registers hold during bubbles.
    always_comb begin
        v1_d    = in_valid;
        prod_d  = prod_q;
        c_d     = c_q;
        mode_d  = mode_q;
        first_d = first_q;
        last_d  = last_q;
        if (in_valid) begin
            prod_d  = ProdW'(at) * ProdW'(bt);
            c_d     = c;
            mode_d  = mode;
            first_d = first;
            last_d  = last;
        end
    end

    // Accumulate onto acc only for a continuing mode-1 term; otherwise start from c.
    always_comb begin
        base = (mode_q && !first_q) ? acc_q : ACC_BITWIDTH'(c_q);
`ifdef CONF_INT_MAC_SAT_EN
        begin
            logic [ACC_BITWIDTH:0] sum;
            sum     = {1'b0, base} + {1'b0, ACC_BITWIDTH'(prod_q)};
            acc_new = sum[ACC_BITWIDTH] ? '1 : sum[ACC_BITWIDTH-1:0];
        end
        clip  = acc_new > ACC_BITWIDTH'({DATA_PATH_BITWIDTH{1'b1}});
        d_val = clip ? '1 : acc_new[DATA_PATH_BITWIDTH-1:0];
`else
        acc_new = base + ACC_BITWIDTH'(prod_q);
        clip    = 1'b0;
        d_val   = acc_new[DATA_PATH_BITWIDTH-1:0];
`endif
    end

    // Stage 2: update accumulator, result, valid pulse and busy.
    always_comb begin
        acc_d       = acc_q;
        d_d         = d_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        sat_d       = 1'b0;
        if (v1_q) begin
            acc_d = acc_new;
            if (!mode_q || last_q) begin
                // Mode 0 always emits and abandons any open accumulation.
                out_valid_d = 1'b1;
                d_d         = d_val;
                busy_d      = 1'b0;
                sat_d       = clip;
            end else if (first_q) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            prod_q      <= '0;
            c_q         <= '0;
            mode_q      <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            acc_q       <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            prod_q      <= prod_d;
            c_q         <= c_d;
            mode_q      <= mode_d;
            first_q     <= first_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sat_q       <= sat_d;
        end
    end

    assign d         = d_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
`ifdef CONF_INT_MAC_SAT_EN
    assign sat       = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_conf_int_mac_pipe_acc.sv
// Bench for conf_int_mac_pipe_acc: a default-width instance (0) and an OP_BITWIDTH=8
// instance (1) share one stimulus stream. A spec-level model predicts every output
// two cycles after the inputs are presented.
module tb_conf_int_mac_pipe_acc;

    logic        clk = 1'b0;
    logic        rst, in_valid, mode, first, last;
    logic [15:0] a, b, c;
    logic [15:0] d0, d1;
    logic        ov0, ov1, busy0, busy1;
`ifdef CONF_INT_MAC_SAT_EN
    logic        sat0, sat1;
`endif

    always #5 clk = ~clk;

    conf_int_mac_pipe_acc u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .first(first), .last(last),
        .a(a), .b(b), .c(c), .d(d0), .out_valid(ov0), .busy(busy0)
`ifdef CONF_INT_MAC_SAT_EN
        , .sat(sat0)
`endif
    );

    conf_int_mac_pipe_acc #(.OP_BITWIDTH(8)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .first(first), .last(last),
        .a(a), .b(b), .c(c), .d(d1), .out_valid(ov1), .busy(busy1)
`ifdef CONF_INT_MAC_SAT_EN
        , .sat(sat1)
`endif
    );

    typedef struct packed {
        logic        ov;
        logic [15:0] d;
        logic        busy;
        logic        sat;
    } exp_t;

    typedef struct packed {
        exp_t i1;
        exp_t i0;
    } pair_t;

    localparam longint unsigned AccMax = (64'd1 << 40) - 64'd1;

    pair_t             pipe[$];
    longint unsigned   m_acc[2];
    logic [15:0]       m_d[2];
    logic              m_busy[2];
    int                vectors = 0;
    int                n_checks = 0;
    int                fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i]  = 0;
            m_d[i]    = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // Behaviour of one accepted term (or bubble) for instance i; returns the visible outputs.
    function automatic exp_t model_step(input int i, input logic v, input logic m,
                                        input logic f, input logic l,
                                        input logic [15:0] aa, input logic [15:0] bb,
                                        input logic [15:0] cc);
        exp_t            e;
        longint unsigned mask, prod, accn;
        logic            emit, clip;
        logic [15:0]     dv;
        mask  = (64'd1 << ((i == 0) ? 16 : 8)) - 64'd1;
        prod  = (64'(aa) & mask) * (64'(bb) & mask);
        e.ov  = 1'b0;
        e.sat = 1'b0;
        if (v) begin
            if (!m)     accn = prod + 64'(cc);
            else if (f) accn = 64'(cc) + prod;
            else        accn = m_acc[i] + prod;
`ifdef CONF_INT_MAC_SAT_EN
            if (accn > AccMax) accn = AccMax;
`else
            accn = accn & AccMax;
`endif
            m_acc[i] = accn;
            emit = !m || l;
            clip = accn > 64'hFFFF;
`ifdef CONF_INT_MAC_SAT_EN
            dv = clip ? 16'hFFFF : accn[15:0];
            e.sat = emit && clip;
`else
            dv = accn[15:0];
`endif
            if (emit) begin
                m_d[i]    = dv;
                m_busy[i] = 1'b0;
            end else if (f) begin
                m_busy[i] = 1'b1;
            end
            e.ov = emit;
        end
        e.d    = m_d[i];
        e.busy = m_busy[i];
        return e;
    endfunction

    task automatic compare(input pair_t p);
        chk("ov0", 32'(ov0), 32'(p.i0.ov));
        chk("d0", 32'(d0), 32'(p.i0.d));
        chk("busy0", 32'(busy0), 32'(p.i0.busy));
        chk("ov1", 32'(ov1), 32'(p.i1.ov));
        chk("d1", 32'(d1), 32'(p.i1.d));
        chk("busy1", 32'(busy1), 32'(p.i1.busy));
`ifdef CONF_INT_MAC_SAT_EN
        chk("sat0", 32'(sat0), 32'(p.i0.sat));
        chk("sat1", 32'(sat1), 32'(p.i1.sat));
`endif
    endtask

    // One clock: drive inputs, advance the model, check whatever reaches the outputs now.
    task automatic cycle(input logic r, input logic v, input logic m, input logic f,
                         input logic l, input logic [15:0] aa, input logic [15:0] bb,
                         input logic [15:0] cc);
        pair_t p;
        rst = r; in_valid = v; mode = m; first = f; last = l; a = aa; b = bb; c = cc;
        if (r) begin
            // In-flight terms vanish; outputs show reset values, then an empty stage 1.
            model_reset();
            pipe.delete();
            p = '0;
            pipe.push_back(p);
            pipe.push_back(p);
        end else begin
            p.i0 = model_step(0, v, m, f, l, aa, bb, cc);
            p.i1 = model_step(1, v, m, f, l, aa, bb, cc);
            pipe.push_back(p);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (pipe.size() == 2) compare(pipe.pop_front());
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        logic        r, v, m, f, l;
        logic [15:0] ra, rb, rc;
        model_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        idle();

        // Single-shot 3*4+5
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd4, 16'd5);
        idle();
        chk("mac_d", 32'(d0), 32'd17);
        chk("mac_ov", 32'(ov0), 32'd1);
        chk("mac_busy", 32'(busy0), 32'd0);

        // Upper operand bits ignored on the 8-bit instance
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0103, 16'h0102, 16'h0);
        idle();
        chk("op8_d", 32'(d1), 32'd6);
        chk("op16_d", 32'(d0), 32'h0506);

        // Output wrap / saturation
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h1);
        idle();
`ifdef CONF_INT_MAC_SAT_EN
        chk("sat_d", 32'(d0), 32'hFFFF);
        chk("sat_flag", 32'(sat0), 32'd1);
`else
        chk("wrap_d", 32'(d0), 32'h0002);
`endif

        // Three-term dot product: 10 + 2*3 + 4*5 + 1*7
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 16'd3, 16'd10);
        chk("dot_busy_a", 32'(busy0), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 16'd5, 16'd0);
        chk("dot_busy_b", 32'(busy0), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd7, 16'd0);
        chk("dot_busy_c", 32'(busy0), 32'd1);
        chk("dot_ov_early", 32'(ov0), 32'd0);
        idle();
        chk("dot_d", 32'(d0), 32'd43);
        chk("dot_ov", 32'(ov0), 32'd1);
        chk("dot_busy_d", 32'(busy0), 32'd0);

        // Reset aborts an open term
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd5, 16'd5, 16'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 16'd1, 16'd0);
        chk("rst_no_ov", 32'(ov0), 32'd0);
        idle();
        chk("rst_d", 32'(d0), 32'd1);
        chk("rst_busy", 32'(busy0), 32'd0);

        // Mode-0 op inside an accumulation: emits 10, then last continues to 10+16
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 16'd3, 16'd100);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd3, 16'd1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd4, 16'd4, 16'd0);
        chk("inj_mac_d", 32'(d0), 32'd10);
        idle();
        chk("inj_last_d", 32'(d0), 32'd26);
        idle();

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            r  = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 3) != 0);
            m  = $urandom_range(0, 1) == 1;
            f  = ($urandom_range(0, 3) == 0);
            l  = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            rc = 16'($urandom);
            cycle(r, v, m, f, l, ra, rb, rc);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
